// File: rtl/datamemory_pkg.sv
// Shared definitions for the RV64 data memory load/store unit.
//   - funct3 encodings for RISC-V loads/stores
//   - FSM state enumeration
//   - size_bytes(): access width in bytes for a funct3
//   - is_legal():   whether a funct3 is allowed for a load or a store
package datamemory_pkg;

   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;
   localparam logic [2:0] F3_WU  = 3'b110;
   localparam logic [2:0] F3_ILL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_e;

   // Width is carried in the low two bits; bit 2 only selects zero-extension.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Unsigned variants have no meaning for stores.
   function automatic logic is_legal(input logic [2:0] funct3, input logic we);
      return !((funct3 == F3_ILL) || (we && funct3[2]));
   endfunction

endpackage

// File: rtl/datamemory_align.sv
// Combinational byte-lane steering between a 64-bit memory word and the
// right-aligned register view.
//   word_i   : current memory word
//   off_i    : byte offset within the word (addr[2:0])
//   funct3_i : RISC-V load/store funct3
//   wdata_i  : right-aligned store data
//   load_o   : selected bytes, sign- or zero-extended to 64 bits
//   mask_o   : per-byte write enable for a store
//   wdata_o  : store data shifted into its byte lanes
module datamemory_align
   import datamemory_pkg::*;
(
   input  logic [63:0] word_i,
   input  logic [2:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] load_o,
   output logic [7:0]  mask_o,
   output logic [63:0] wdata_o
);

   logic [5:0]  bit_off;
   logic [63:0] shifted;
   logic [7:0]  base_mask;

   assign bit_off = {off_i, 3'b000};
   assign shifted = word_i >> bit_off;

   always_comb begin
      load_o = shifted;
      case (funct3_i)
         F3_B:    load_o = {{56{shifted[7]}},  shifted[7:0]};
         F3_H:    load_o = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    load_o = {{32{shifted[31]}}, shifted[31:0]};
         F3_BU:   load_o = {56'd0, shifted[7:0]};
         F3_HU:   load_o = {48'd0, shifted[15:0]};
         F3_WU:   load_o = {32'd0, shifted[31:0]};
         default: load_o = shifted;
      endcase
   end

   always_comb begin
      base_mask = 8'hFF;
      case (funct3_i[1:0])
         2'b00:   base_mask = 8'h01;
         2'b01:   base_mask = 8'h03;
         2'b10:   base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
   end

   // Misaligned offsets would spill bits off the top here, but such
   // accesses are rejected before the mask is ever used.
   assign mask_o  = base_mask << off_i;
   assign wdata_o = wdata_i << bit_off;

endmodule

// File: rtl/datamemory_lsu.sv
// Byte-addressed RV64 data memory with valid/ready request and response.
//   clk_i, rst_n_i         : clock (rising edge), async active-low reset
//   req_valid_i/ready_o    : request handshake (ready only in IDLE)
//   req_we_i               : 1 = store, 0 = load
//   req_funct3_i           : RISC-V load/store funct3
//   req_addr_i             : byte address
//   req_wdata_i            : right-aligned store data
//   rsp_valid_o/ready_i    : response handshake
//   rsp_rdata_o            : extended load data, 0 for stores and errors
//   rsp_err_o              : illegal funct3, misaligned or out-of-range
// One access in flight: IDLE -> [WAIT x LATENCY] -> ACCESS -> RESP.
module datamemory_lsu
   import datamemory_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [63:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [63:0]       rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef logic [63:0] mem_t [DEPTH];

   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) m[i] = (i == 16) ? 64'd731 : 64'd0;
      return m;
   endfunction

   // Storage is deliberately outside the reset domain.
   mem_t mem_q = mem_init();

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic [63:0]       rdata_q;
   logic              err_q;

   logic              accept;
   logic [31:0]       word_idx;
   logic              in_range;
   logic [IDX_W-1:0]  widx;
   logic [3:0]        sz;
   logic              misal;
   logic              acc_err;
   logic [63:0]       rd_word;
   logic [63:0]       load_val;
   logic [7:0]        st_mask;
   logic [63:0]       st_data;
   logic              wr_en;

   assign accept = (state_q == ST_IDLE) && req_valid_i;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
               cnt_d   = CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- request capture ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else if (accept) begin
         we_q     <= req_we_i;
         funct3_q <= req_funct3_i;
         addr_q   <= req_addr_i;
         wdata_q  <= req_wdata_i;
      end
   end

   // ---------------- access decode ----------------
   assign word_idx = 32'(addr_q[ADDR_W-1:3]);
   assign in_range = (word_idx < 32'(DEPTH));
   assign widx     = addr_q[3 +: IDX_W];
   assign sz       = size_bytes(funct3_q);
   assign misal    = (addr_q[2:0] & 3'(sz - 4'd1)) != 3'd0;
   assign acc_err  = !is_legal(funct3_q, we_q) || misal || !in_range;
   // widx can exceed DEPTH-1 for non power-of-two depths; keep it gated.
   assign rd_word  = in_range ? mem_q[widx] : 64'd0;
   assign wr_en    = (state_q == ST_ACCESS) && we_q && !acc_err;

   datamemory_align u_align (
      .word_i   (rd_word),
      .off_i    (addr_q[2:0]),
      .funct3_i (funct3_q),
      .wdata_i  (wdata_q),
      .load_o   (load_val),
      .mask_o   (st_mask),
      .wdata_o  (st_data)
   );

   // An async reset drops state_q out of ACCESS, so an interrupted access
   // never reaches this write.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 8; b++) begin
            if (st_mask[b]) mem_q[widx][b*8 +: 8] <= st_data[b*8 +: 8];
         end
      end
   end

   // ---------------- response ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
         rdata_q <= (acc_err || we_q) ? 64'd0 : load_val;
         err_q   <= acc_err;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_datamemory_lsu.sv
// Directed bench: three instances share one clock.
//   0 : DEPTH=32, LATENCY=0   1 : DEPTH=16, LATENCY=0   2 : DEPTH=32, LATENCY=3
module tb_datamemory_lsu;

   logic        clk;
   logic        rst_n     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [2:0]  req_f3    [3];
   logic [7:0]  req_addr  [3];
   logic [63:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [63:0] rsp_rdata [3];
   logic        rsp_err   [3];

   int pass_cnt = 0;
   int total    = 0;

   logic [63:0] rd;
   logic        er;
   int          n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   datamemory_lsu #(.DEPTH(32), .ADDR_W(8), .LATENCY(0)) u_d0 (
      .clk_i(clk), .rst_n_i(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]), .req_addr_i(req_addr[0]),
      .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

   datamemory_lsu #(.DEPTH(16), .ADDR_W(8), .LATENCY(0)) u_d1 (
      .clk_i(clk), .rst_n_i(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]), .req_addr_i(req_addr[1]),
      .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

   datamemory_lsu #(.DEPTH(32), .ADDR_W(8), .LATENCY(3)) u_d2 (
      .clk_i(clk), .rst_n_i(rst_n[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
      .req_we_i(req_we[2]), .req_funct3_i(req_f3[2]), .req_addr_i(req_addr[2]),
      .req_wdata_i(req_wdata[2]), .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
      .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

   // One full transaction on instance d. n = negedges from accept edge
   // until rsp_valid is seen (LATENCY+2 when on time, 40 on timeout).
   task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [63:0] wd,
                         output logic [63:0] rdo, output logic ero, output int no);
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3;
      req_addr[d] = addr;  req_wdata[d] = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      no = 1;
      while (!rsp_valid[d] && no < 40) begin
         @(negedge clk);
         no++;
      end
      rdo = rsp_rdata[d];
      ero = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = 3'd0;
         req_addr[d] = 8'd0; req_wdata[d] = 64'd0; rsp_ready[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if ({req_ready[d], rsp_valid[d], rsp_err[d]} !== 3'b100 || rsp_rdata[d] !== 64'd0)
            $display("FAIL reset[%0d]: got rdy=%b vld=%b err=%b rdata=%h exp 1 0 0 0",
                     d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
         else pass_cnt++;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
   endtask

   task automatic test_init_load();
      do_req(0, 1'b0, 3'b011, 8'd128, 64'd0, rd, er, n);
      total++; if (n !== 2) $display("FAIL ld128_latency: got %0d exp 2", n); else pass_cnt++;
      total++; if (rd !== 64'd731 || er !== 1'b0)
         $display("FAIL ld128: got %h err=%b exp 2db err=0", rd, er); else pass_cnt++;
   endtask

   task automatic test_store_loads();
      do_req(0, 1'b1, 3'b011, 8'd0, 64'h8877665544332211, rd, er, n);
      total++; if (rd !== 64'd0 || er !== 1'b0)
         $display("FAIL sd0: got %h err=%b exp 0 err=0", rd, er); else pass_cnt++;
      do_req(0, 1'b0, 3'b000, 8'd7, 64'd0, rd, er, n);
      total++; if (rd !== 64'hFFFFFFFFFFFFFF88) $display("FAIL lb7: got %h exp ffffffffffffff88", rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b100, 8'd7, 64'd0, rd, er, n);
      total++; if (rd !== 64'h88) $display("FAIL lbu7: got %h exp 88", rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b001, 8'd6, 64'd0, rd, er, n);
      total++; if (rd !== 64'hFFFFFFFFFFFF8877) $display("FAIL lh6: got %h exp ffffffffffff8877", rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b110, 8'd4, 64'd0, rd, er, n);
      total++; if (rd !== 64'h88776655) $display("FAIL lwu4: got %h exp 88776655", rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b010, 8'd4, 64'd0, rd, er, n);
      total++; if (rd !== 64'hFFFFFFFF88776655) $display("FAIL lw4: got %h exp ffffffff88776655", rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b101, 8'd2, 64'd0, rd, er, n);
      total++; if (rd !== 64'h4433) $display("FAIL lhu2: got %h exp 4433", rd); else pass_cnt++;
   endtask

   task automatic test_byte_store();
      // Upper bits of wdata must not leak into neighbouring lanes.
      do_req(0, 1'b1, 3'b000, 8'd3, 64'hFFFFFFFFFFFFFFAB, rd, er, n);
      do_req(0, 1'b0, 3'b011, 8'd0, 64'd0, rd, er, n);
      total++; if (rd !== 64'h88776655AB332211) $display("FAIL sb3_ld0: got %h exp 88776655ab332211", rd); else pass_cnt++;
   endtask

   task automatic test_errors();
      do_req(0, 1'b0, 3'b010, 8'd2, 64'd0, rd, er, n);
      total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL lw2_misal: got err=%b %h exp err=1 0", er, rd); else pass_cnt++;
      do_req(0, 1'b1, 3'b001, 8'd1, 64'hFFFF, rd, er, n);
      total++; if (er !== 1'b1) $display("FAIL sh1_misal: got err=%b exp 1", er); else pass_cnt++;
      do_req(0, 1'b1, 3'b100, 8'd0, 64'hFF, rd, er, n);
      total++; if (er !== 1'b1) $display("FAIL sbu_illegal: got err=%b exp 1", er); else pass_cnt++;
      do_req(0, 1'b0, 3'b011, 8'd0, 64'd0, rd, er, n);
      total++; if (rd !== 64'h88776655AB332211 || er !== 1'b0)
         $display("FAIL ld0_unchanged: got %h err=%b exp 88776655ab332211 err=0", rd, er); else pass_cnt++;
      do_req(0, 1'b0, 3'b111, 8'd0, 64'd0, rd, er, n);
      total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL f3_111: got err=%b %h exp err=1 0", er, rd); else pass_cnt++;
      do_req(0, 1'b0, 3'b011, 8'd248, 64'd0, rd, er, n);
      total++; if (er !== 1'b0) $display("FAIL ld_lastword: got err=%b exp 0", er); else pass_cnt++;
      do_req(1, 1'b0, 3'b011, 8'd128, 64'd0, rd, er, n);
      total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL d16_ld128: got err=%b %h exp err=1 0", er, rd); else pass_cnt++;
      do_req(1, 1'b0, 3'b011, 8'd120, 64'd0, rd, er, n);
      total++; if (er !== 1'b0 || rd !== 64'd0) $display("FAIL d16_ld120: got err=%b %h exp err=0 0", er, rd); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b0; req_f3[2] = 3'b011; req_addr[2] = 8'd128;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      n = 1;
      while (!rsp_valid[2] && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++; if (n !== 5) $display("FAIL lat3_latency: got %0d exp 5", n); else pass_cnt++;
      // Hold the response while offering a competing store that must be dropped.
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_f3[2] = 3'b011; req_addr[2] = 8'd128;
      req_wdata[2] = 64'h55;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({rsp_valid[2], req_ready[2], rsp_err[2]} !== 3'b100 || rsp_rdata[2] !== 64'd731)
            $display("FAIL hold[%0d]: got vld=%b rdy=%b err=%b rdata=%h exp 1 0 0 2db",
                     i, rsp_valid[2], req_ready[2], rsp_err[2], rsp_rdata[2]);
         else pass_cnt++;
      end
      req_valid[2] = 1'b0;
      rsp_ready[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[2] = 1'b0;
      total++; if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0)
         $display("FAIL after_hs: got rdy=%b vld=%b exp 1 0", req_ready[2], rsp_valid[2]); else pass_cnt++;
      do_req(2, 1'b0, 3'b011, 8'd128, 64'd0, rd, er, n);
      total++; if (rd !== 64'd731) $display("FAIL ignored_store: got %h exp 2db", rd); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_f3[2] = 3'b011; req_addr[2] = 8'd8;
      req_wdata[2] = 64'h1234;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      #2 rst_n[2] = 1'b0;
      #1;
      total++;
      if ({req_ready[2], rsp_valid[2], rsp_err[2]} !== 3'b100 || rsp_rdata[2] !== 64'd0)
         $display("FAIL mid_reset: got rdy=%b vld=%b err=%b rdata=%h exp 1 0 0 0",
                  req_ready[2], rsp_valid[2], rsp_err[2], rsp_rdata[2]);
      else pass_cnt++;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      do_req(2, 1'b0, 3'b011, 8'd8, 64'd0, rd, er, n);
      total++; if (rd !== 64'd0 || er !== 1'b0) $display("FAIL ld8_after_abort: got %h err=%b exp 0 err=0", rd, er); else pass_cnt++;
      do_req(2, 1'b0, 3'b011, 8'd128, 64'd0, rd, er, n);
      total++; if (rd !== 64'd731) $display("FAIL mem_kept: got %h exp 2db", rd); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_init_load();
      test_store_loads();
      test_byte_store();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/datamemory_lsu.md
# datamemory_lsu

Parametrised, byte-addressed RV64 data memory with a valid/ready request/response interface. It supports every RISC-V load/store size: byte, half, word and double, with sign or zero extension. It detects misaligned, out-of-range and illegal accesses, and can model configurable access latency. It sits between the pipeline's memory stage and the data storage, and replaces the fixed single-cycle 32×64 word memory.

## Interface
- `DEPTH`, 32: number of 64-bit words, ≥1.
- `ADDR_W`, 8: byte-address width; must satisfy 2^(ADDR_W-3) ≥ DEPTH.
- `LATENCY`, 0: extra wait cycles per access, 0..15.

- `CLK`  in  1  clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  block can accept a request.
- `REQ_WE`  in  1  1 = store, 0 = load.
- `REQ_FUNCT3`  in  3  RISC-V load/store funct3.
- `REQ_ADDR`  in  ADDR_W  byte address.
- `REQ_WDATA`  in  64  store data, right-aligned.
- `RSP_VALID`  out  1  response present.
- `RSP_READY`  in  1  consumer accepts response.
- `RSP_RDATA`  out  64  load result, extended; 0 for stores and errors.
- `RSP_ERR`  out  1  access rejected.

## Operation
- **funct3 encoding:** 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU. 111 is illegal. 100–110 are illegal for stores.
- **Error conditions:** an access is an error if any of the following holds:
  - funct3 is illegal for the access type;
  - the address is not a multiple of the access size (misaligned);
  - the word index `REQ_ADDR[ADDR_W-1:3]` ≥ DEPTH.
- **Error behaviour:** no memory write; `RSP_RDATA` = 0; `RSP_ERR` = 1.
- **Loads:** select bytes using `addr[2:0]`. Signed sizes sign-extend to 64 bits; unsigned sizes zero-extend.
- **Stores:** generate a byte mask from size and `addr[2:0]`. Write only the masked bytes with `REQ_WDATA` shifted into lane position; other bytes are preserved.
- **FSM states:**
  - IDLE: `REQ_READY` = 1. `REQ_VALID` captures addr, funct3, we and wdata; go to WAIT if LATENCY > 0, otherwise ACCESS.
  - WAIT: counter loaded with LATENCY−1 on accept, decremented each cycle; at 0, go to ACCESS.
  - ACCESS: on the closing edge, commit the store or register the load data and error; go to RESP.
  - RESP: `RSP_VALID` = 1 with stable `RSP_RDATA` and `RSP_ERR`. `RSP_READY` returns to IDLE.
- `REQ_VALID` is ignored outside IDLE. Requests are not queued.
- **Reset (asynchronous):**
  - State IDLE, counter 0.
  - `RSP_VALID` = 0, `RSP_RDATA` = 0, `RSP_ERR` = 0, `REQ_READY` = 1.
  - Memory contents are not reset.
- **Reset mid-operation:** if reset asserts before the ACCESS closing edge, the access is aborted and memory is unchanged.
- **Simulation initial contents:** all zero, except word 16 = 731.

## Timing
- Accept at edge E0. ACCESS occupies the cycle after E(LATENCY). `RSP_VALID` rises after edge E(LATENCY+1).
- With LATENCY=0, `RSP_VALID` is high in the cycle after E1.
- A response handshake at edge En gives `REQ_READY` = 1 in the cycle after En. The next accept is at E(n+1) at the earliest.
- Best-case throughput: one access per LATENCY+3 cycles.
- A load issued after a store's response sees the stored data (no hazard window).
- `REQ_READY` is decoded from state only; there is no combinational path from any input.

## Structure
- **Shared package `datamemory_pkg`:**
  - funct3 constants;
  - FSM state enum;
  - `size_bytes(funct3)` function;
  - `is_legal(funct3, we)` function.
- **Sub-module `datamemory_align` (combinational):**
  - inputs: 64-bit word, `addr[2:0]`, funct3, wdata;
  - outputs: extended load value, store byte mask, lane-shifted store data.
- The top level holds the storage array, the FSM, the latency counter and the response registers.

## Test plan
- Reset, LATENCY=0, LD addr 128 → `RSP_VALID` after E1, `RSP_RDATA` = 731, `RSP_ERR` = 0.
- SD 0x8877665544332211 to addr 0, then the following loads:
  - LB 7 → 0xFFFFFFFFFFFFFF88;
  - LBU 7 → 0x88;
  - LH 6 → 0xFFFFFFFFFFFF8877;
  - LWU 4 → 0x88776655.
- SB 0xAB to addr 3, then LD 0 → 0x88776655AB332211.
- LW addr 2 → `RSP_ERR` = 1, `RSP_RDATA` = 0. SH addr 1 → error, and a following LD 0 is unchanged. Store with funct3 100 → error. DEPTH=16, LD addr 128 → error.
- LATENCY=3, `RSP_READY` low for 5 cycles → `RSP_VALID`, `RSP_RDATA` and `RSP_ERR` stay stable, `REQ_READY` = 0, and a second `REQ_VALID` is ignored.
- SD 0x1234 to addr 8 with LATENCY=3, `RST_N` pulsed low during WAIT → outputs return to reset values immediately, and LD 8 afterwards → 0.
